ahb_subordinate_mem: RTL and testbench
======================================

// Module: ahb_subordinate_mem
// PURPOSE
//  AHB-Lite subordinate (responder) with a word-addressed SRAM behind it.
//  Drives the completion side of the AHB pin-level interface: HRDATA, HREADYOUT, HRESP, HEXOKAY.
//  Used as the DUT-side target for manager-agent traffic in the AVIP.
//  Supports programmable wait states, byte strobes, and the two-cycle ERROR response.
// PARAMETERS
//  ADDR_WIDTH   32   HADDR width
//  DATA_WIDTH   32   HWDATA/HRDATA width; allowed values 32 or 64
//  MEM_DEPTH    256  number of DATA_WIDTH words; byte range = MEM_DEPTH*DATA_WIDTH/8
//  WAIT_STATES  0    HREADYOUT-low cycles inserted before every OKAY data phase (0..15)
// PORTS
//  HCLK       in   1             clock, rising edge
//  HRESETn    in   1             asynchronous active-low reset
//  HSELx      in   1             this subordinate's select bit
//  HADDR      in   ADDR_WIDTH    byte address (address phase)
//  HTRANS     in   2             IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//  HWRITE     in   1             1=write, 0=read
//  HSIZE      in   3             transfer size, bytes = 2**HSIZE
//  HBURST     in   3             accepted, not used (each beat decoded independently)
//  HPROT      in   HPROT_WIDTH   accepted, not used
//  HEXCL      in   1             exclusive request; not supported
//  HWDATA     in   DATA_WIDTH    write data (data phase)
//  HWSTRB     in   DATA_WIDTH/8  write byte strobes (data phase)
//  HREADY     in   1             combined bus ready
//  HRDATA     out  DATA_WIDTH    read data
//  HREADYOUT  out  1             this subordinate's ready
//  HRESP      out  1             0=OKAY, 1=ERROR
//  HEXOKAY    out  1             exclusive-okay; constant 0
// BEHAVIOUR
//  Reset (async, HRESETn=0): HREADYOUT=1, HRESP=0, HRDATA=0, HEXOKAY=0; FSM=IDLE; memory contents not reset.
//  Accept: at a rising edge with HSELx & HREADY & HTRANS[1], latch addr/write/size into *_q.
//    IDLE/BUSY, or HSELx=0, under HREADY: next data phase is zero-wait OKAY and has no side effects.
//  Error check at accept; any one condition gives ERROR:
//    word index >= MEM_DEPTH
//    HADDR not aligned to 2**HSIZE
//    2**HSIZE > DATA_WIDTH/8
//  FSM states:
//    IDLE -> WAIT   when a good transfer is accepted and WAIT_STATES>0
//    IDLE -> DATA   when a good transfer is accepted and WAIT_STATES==0
//    IDLE -> ERR1   when a bad transfer is accepted
//    WAIT           HREADYOUT=0, HRESP=0; wait counter decrements; goes to DATA when it reaches 1
//    DATA           HREADYOUT=1, HRESP=0; transfer completes this cycle
//    ERR1           HREADYOUT=0, HRESP=1; always goes to ERR2
//    ERR2           HREADYOUT=1, HRESP=1
//    Leaving DATA/ERR2: re-evaluate accept in the same edge (back-to-back pipelining);
//      otherwise go to IDLE.
//  Latency: OKAY data phase lasts WAIT_STATES+1 cycles; ERROR data phase always lasts 2 cycles.
//  Write: commits at the DATA-state edge.
//    Byte enable = HWSTRB & lane_mask(addr_q[lsb], size_q).
//    Bytes whose enable is 0 are unchanged. No write on ERROR.
//  Read: HRDATA = mem[addr_q word] while in DATA state and the transfer is a read; otherwise HRDATA=0.
//    All lanes of the word are driven; the manager selects lanes.
//  Write then read of the same address back-to-back: the read returns the newly written bytes
//    (write commits before the read's data phase).
//  ERR1 state: a manager may present IDLE with HREADY low; it is ignored.
//    No new accept is possible while HREADY=0.
//  HEXCL=1 is treated as a normal transfer; HEXOKAY stays 0.
//  Reset asserted mid-transfer: in-flight write is dropped; outputs go to reset values immediately.
// STRUCTURE
//  AhbGlobalPackage gains:
//    typedef enum logic[1:0] ahb_htrans_e {IDLE,BUSY,NONSEQ,SEQ}
//    typedef enum logic[2:0] ahb_hsize_e
//    typedef enum logic ahb_hresp_e {OKAY,ERROR}
//    function lane_mask(addr_lsb, hsize)
//  Sub-module ahb_sub_mem_array holds the storage:
//    MEM_DEPTH x DATA_WIDTH
//    per-byte write enable
//    combinational read port
// TESTING
//  1. WAIT_STATES=0: NONSEQ write 0xDEADBEEF to 0x10, then read 0x10
//       -> HREADYOUT never low; HRESP=0; HRDATA=0xDEADBEEF.
//  2. WAIT_STATES=3: single read
//       -> HREADYOUT low exactly 3 cycles, then high with data.
//     Back-to-back NONSEQ reads
//       -> each takes 4 cycles.
//  3. Byte write HSIZE=0 to 0x13, HWDATA=0xAB000000, HWSTRB=4'hF, over word 0x11223344
//       -> read of 0x10 returns 0xAB223344.
//  4. Read of 0x2 with HSIZE=2, then read of byte address MEM_DEPTH*4
//       -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1);
//          memory unchanged.
//  5. Write 0x5A5A5A5A to 0x20 immediately followed by read of 0x20 (pipelined)
//       -> HRDATA=0x5A5A5A5A.
//     IDLE/BUSY beats interleaved
//       -> OKAY, zero wait.
//  6. Assert HRESETn low during WAIT of a write to 0x30
//       -> HREADYOUT=1, HRESP=0 asynchronously; later read of 0x30 returns the prior contents.

Source files
------------

// File: rtl/ahb_subordinate_mem_pkg.sv
// rtl/ahb_subordinate_mem_pkg.sv - AHB-Lite encodings, FSM states and lane-mask helper
package ahb_subordinate_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        NONSEQ = 2'd2,
        SEQ    = 2'd3
    } ahb_htrans_e;

    typedef enum logic [2:0] {
        HSIZE_8    = 3'd0,
        HSIZE_16   = 3'd1,
        HSIZE_32   = 3'd2,
        HSIZE_64   = 3'd3,
        HSIZE_128  = 3'd4,
        HSIZE_256  = 3'd5,
        HSIZE_512  = 3'd6,
        HSIZE_1024 = 3'd7
    } ahb_hsize_e;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } ahb_hresp_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } sub_state_e;

    // Byte lanes touched by a 2**hsize transfer starting at byte offset addr_lsb.
    function automatic logic [7:0] lane_mask(input logic [2:0] addr_lsb, input logic [2:0] hsize);
        logic [15:0] m;
        m = (16'd1 << (5'd1 << hsize)) - 16'd1;
        m = m << addr_lsb;
        return m[7:0];
    endfunction

endpackage

// File: rtl/ahb_subordinate_mem_if.sv
// rtl/ahb_subordinate_mem_if.sv - AHB-Lite pin-level bundle between manager side and subordinate
interface ahb_subordinate_mem_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int HPROT_WIDTH = 4
);
    logic                    HSELx;
    logic [ADDR_WIDTH-1:0]   HADDR;
    logic [1:0]              HTRANS;
    logic                    HWRITE;
    logic [2:0]              HSIZE;
    logic [2:0]              HBURST;
    logic [HPROT_WIDTH-1:0]  HPROT;
    logic                    HEXCL;
    logic [DATA_WIDTH-1:0]   HWDATA;
    logic [DATA_WIDTH/8-1:0] HWSTRB;
    logic                    HREADY;
    logic [DATA_WIDTH-1:0]   HRDATA;
    logic                    HREADYOUT;
    logic                    HRESP;
    logic                    HEXOKAY;

    modport master (
        output HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HEXCL,
               HWDATA, HWSTRB, HREADY,
        input  HRDATA, HREADYOUT, HRESP, HEXOKAY
    );

    modport slave (
        input  HSELx, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HEXCL,
               HWDATA, HWSTRB, HREADY,
        output HRDATA, HREADYOUT, HRESP, HEXOKAY
    );
endinterface

// File: rtl/ahb_sub_mem_array.sv
// rtl/ahb_sub_mem_array.sv - word-addressed storage with per-byte write enable and async read
module ahb_sub_mem_array #(
    parameter int DATA_WIDTH = 32,
    parameter int MEM_DEPTH  = 256,
    localparam int STRB_W    = DATA_WIDTH / 8,
    localparam int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [STRB_W-1:0]     be_i,
    input  logic [IDX_W-1:0]      addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];
endmodule

// File: rtl/ahb_subordinate_mem.sv
// rtl/ahb_subordinate_mem.sv - AHB-Lite subordinate fronting an SRAM, with wait states and ERROR
module ahb_subordinate_mem
    import ahb_subordinate_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic           HCLK,
    input  logic           HRESETn,
    ahb_subordinate_mem_if.slave bus
);
    localparam int STRB_W   = DATA_WIDTH / 8;
    localparam int BYTE_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(MEM_DEPTH);
    localparam int AQ_W     = IDX_W + BYTE_LSB;

    sub_state_e          state_q, state_d;
    logic [AQ_W-1:0]     addr_q, addr_d;
    logic                write_q, write_d;
    logic [2:0]          size_q, size_d;
    logic [3:0]          wcnt_q, wcnt_d;

    ahb_htrans_e         htrans;
    ahb_hresp_e          hresp;
    logic                accept;
    logic                bad_range, bad_align, bad_size, bad_xfer;
    logic [7:0]          align_mask;
    logic [7:0]          lanes;
    logic                mem_we;
    logic [STRB_W-1:0]   byte_en;
    logic [DATA_WIDTH-1:0] rdata;

    assign htrans = ahb_htrans_e'(bus.HTRANS);
    assign accept = bus.HSELx && bus.HREADY && (htrans == NONSEQ || htrans == SEQ);

    assign align_mask = 8'((9'd1 << bus.HSIZE) - 9'd1);
    assign bad_range  = (bus.HADDR >> BYTE_LSB) >= ADDR_WIDTH'(MEM_DEPTH);
    assign bad_align  = |(bus.HADDR[7:0] & align_mask);
    assign bad_size   = bus.HSIZE > 3'(BYTE_LSB);
    assign bad_xfer   = bad_range || bad_align || bad_size;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            wcnt_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            wcnt_q  <= wcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            ST_WAIT: begin
                if (wcnt_q == 4'd1) state_d = ST_DATA;
                else                wcnt_d  = wcnt_q - 4'd1;
            end
            ST_ERR1: state_d = ST_ERR2;
            default: state_d = ST_IDLE;
        endcase
        // Completing states may take the next address phase on the same edge.
        if ((state_q == ST_IDLE || state_q == ST_DATA || state_q == ST_ERR2) && accept) begin
            addr_d  = bus.HADDR[AQ_W-1:0];
            write_d = bus.HWRITE;
            size_d  = bus.HSIZE;
            if (bad_xfer) begin
                state_d = ST_ERR1;
            end else if (WAIT_STATES > 0) begin
                state_d = ST_WAIT;
                wcnt_d  = 4'(WAIT_STATES);
            end else begin
                state_d = ST_DATA;
            end
        end
    end

    assign lanes   = lane_mask(3'(addr_q[BYTE_LSB-1:0]), size_q);
    assign mem_we  = (state_q == ST_DATA) && write_q;
    assign byte_en = bus.HWSTRB & lanes[STRB_W-1:0];

    ahb_sub_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_mem (
        .clk_i   (HCLK),
        .we_i    (mem_we),
        .be_i    (byte_en),
        .addr_i  (addr_q[AQ_W-1:BYTE_LSB]),
        .wdata_i (bus.HWDATA),
        .rdata_o (rdata)
    );

    assign hresp         = (state_q == ST_ERR1 || state_q == ST_ERR2) ? ERROR : OKAY;
    assign bus.HRESP     = hresp;
    assign bus.HREADYOUT = (state_q != ST_WAIT) && (state_q != ST_ERR1);
    assign bus.HRDATA    = (state_q == ST_DATA && !write_q) ? rdata : '0;
    assign bus.HEXOKAY   = 1'b0;
endmodule

// File: tb/tb_ahb_subordinate_mem.sv
// tb/tb_ahb_subordinate_mem.sv - two subordinates (0 and 3 wait states) on one bus vs a byte-array model
module tb_ahb_subordinate_mem;
    localparam int DEPTH = 32;
    localparam int NBYTE = DEPTH * 4;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    always #5 HCLK = ~HCLK;

    ahb_subordinate_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HPROT_WIDTH(4)) s_if0 ();
    ahb_subordinate_mem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .HPROT_WIDTH(4)) s_if1 ();

    ahb_subordinate_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(0))
        dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(s_if0));
    ahb_subordinate_mem #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(DEPTH), .WAIT_STATES(3))
        dut1 (.HCLK(HCLK), .HRESETn(HRESETn), .bus(s_if1));

    logic        m_sel = 1'b0;
    logic [1:0]  m_trans = 2'd0;
    logic        m_write = 1'b0;
    logic [2:0]  m_size = 3'd2;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic        m_excl = 1'b0;
    logic [2:0]  m_burst = '0;
    logic [3:0]  m_prot = '0;
    logic        sel_dp;

    wire         bus_ready = sel_dp ? s_if1.HREADYOUT : s_if0.HREADYOUT;
    wire         bus_resp  = sel_dp ? s_if1.HRESP     : s_if0.HRESP;
    wire [31:0]  bus_rdata = sel_dp ? s_if1.HRDATA    : s_if0.HRDATA;
    wire         bus_exok  = sel_dp ? s_if1.HEXOKAY   : s_if0.HEXOKAY;

    assign s_if0.HSELx = (m_sel == 1'b0);
    assign s_if1.HSELx = (m_sel == 1'b1);
    assign {s_if0.HADDR,  s_if1.HADDR}  = {m_addr, m_addr};
    assign {s_if0.HTRANS, s_if1.HTRANS} = {m_trans, m_trans};
    assign {s_if0.HWRITE, s_if1.HWRITE} = {m_write, m_write};
    assign {s_if0.HSIZE,  s_if1.HSIZE}  = {m_size, m_size};
    assign {s_if0.HBURST, s_if1.HBURST} = {m_burst, m_burst};
    assign {s_if0.HPROT,  s_if1.HPROT}  = {m_prot, m_prot};
    assign {s_if0.HEXCL,  s_if1.HEXCL}  = {m_excl, m_excl};
    assign {s_if0.HWDATA, s_if1.HWDATA} = {m_wdata, m_wdata};
    assign {s_if0.HWSTRB, s_if1.HWSTRB} = {m_wstrb, m_wstrb};
    assign s_if0.HREADY = bus_ready;
    assign s_if1.HREADY = bus_ready;

    // Interconnect: remembers which subordinate owns the current data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)       sel_dp <= 1'b0;
        else if (bus_ready) sel_dp <= m_sel;
    end

    typedef struct {
        logic        s;
        logic [1:0]  tr;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
    } beat_t;

    beat_t       q[$];
    logic [7:0]  mdl [2][NBYTE];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_err(input beat_t b);
        return ((b.a >> 2) >= 32'(DEPTH)) || ((b.a % (32'd1 << b.sz)) != 0) || ((32'd1 << b.sz) > 32'd4);
    endfunction

    function automatic logic [31:0] model_word(input logic s, input logic [31:0] a);
        int base;
        base = int'(a & ~32'd3);
        return {mdl[s][base+3], mdl[s][base+2], mdl[s][base+1], mdl[s][base]};
    endfunction

    task automatic push(input logic s, input logic [1:0] tr, input logic w, input logic [2:0] sz,
                        input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st);
        beat_t b;
        b.s = s; b.tr = tr; b.w = w; b.sz = sz; b.a = a; b.wd = wd; b.st = st;
        q.push_back(b);
    endtask

    task automatic complete(input beat_t b, input int waits, input bit resp_bad,
                            input logic rsp, input logic [31:0] rd, input logic exo);
        bit          active, err;
        int          exp_waits;
        logic [31:0] exp_rd;
        int          byte_a;
        active    = b.tr[1];
        err       = active && is_err(b);
        exp_waits = !active ? 0 : (err ? 1 : (b.s ? 3 : 0));
        exp_rd    = '0;
        if (active && !err && b.w) begin
            for (int i = 0; i < (1 << b.sz); i++) begin
                byte_a = int'(b.a) + i;
                if (b.st[byte_a % 4]) mdl[b.s][byte_a] = b.wd[8*(byte_a % 4) +: 8];
            end
        end
        if (active && !err && !b.w) begin
            exp_rd  = model_word(b.s, b.a);
            last_rd = rd;
        end
        check_eq("waits", 64'(waits), 64'(exp_waits));
        check_eq("hresp", 64'(rsp), 64'(err));
        check_eq("wait_hresp", 64'(resp_bad), 64'd0);
        check_eq("hrdata", 64'(rd), 64'(exp_rd));
        check_eq("hexokay", 64'(exo), 64'd0);
    endtask

    // Pipelined manager: address phase of beat ap overlaps data phase of beat dp.
    task automatic run();
        int   ap, dp, waits, budget;
        bit   resp_bad, rdy;
        logic rsp, exo;
        logic [31:0] rd;
        ap = 0; dp = -1; waits = 0; budget = 0; resp_bad = 0;
        while ((ap < q.size() || dp >= 0) && budget < 20000) begin
            if (ap < q.size()) begin
                m_sel = q[ap].s; m_trans = q[ap].tr; m_write = q[ap].w;
                m_size = q[ap].sz; m_addr = q[ap].a;
                m_excl = 1'($urandom); m_burst = 3'($urandom); m_prot = 4'($urandom);
            end else begin
                m_trans = 2'd0;
            end
            if (dp >= 0) begin
                m_wdata = q[dp].wd; m_wstrb = q[dp].st;
            end
            @(negedge HCLK);
            rdy = bus_ready; rsp = bus_resp; rd = bus_rdata; exo = bus_exok;
            @(posedge HCLK); #1;
            budget++;
            if (dp >= 0) begin
                if (!rdy) begin
                    waits++;
                    if (rsp != (q[dp].tr[1] && is_err(q[dp]))) resp_bad = 1;
                end else begin
                    complete(q[dp], waits, resp_bad, rsp, rd, exo);
                    waits = 0; resp_bad = 0;
                end
            end
            if (rdy) begin
                if (ap < q.size()) begin dp = ap; ap++; end
                else dp = -1;
            end
        end
        if (budget >= 20000) check_eq("timeout", 64'd1, 64'd0);
        q.delete();
    endtask

    logic [31:0] saved;

    initial begin
        #1;
        check_eq("rst_rdy0", 64'(s_if0.HREADYOUT), 64'd1);
        check_eq("rst_resp0", 64'(s_if0.HRESP), 64'd0);
        check_eq("rst_rd0", 64'(s_if0.HRDATA), 64'd0);
        check_eq("rst_rdy1", 64'(s_if1.HREADYOUT), 64'd1);
        check_eq("rst_resp1", 64'(s_if1.HRESP), 64'd0);
        check_eq("rst_exok1", 64'(s_if1.HEXOKAY), 64'd0);
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;

        for (int s = 0; s < 2; s++)
            for (int w = 0; w < DEPTH; w++)
                push(1'(s), 2'd2, 1'b1, 3'd2, 32'(w * 4), $urandom, 4'hF);
        run();

        push(1'b0, 2'd2, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 4'hF);
        push(1'b0, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 4'h0);
        run();
        check_eq("t1_rd", 64'(last_rd), 64'hDEADBEEF);

        push(1'b1, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 4'h0);
        run();
        push(1'b1, 2'd2, 1'b0, 3'd2, 32'h14, 32'h0, 4'h0);
        push(1'b1, 2'd2, 1'b0, 3'd2, 32'h18, 32'h0, 4'h0);
        run();

        push(1'b0, 2'd2, 1'b1, 3'd2, 32'h10, 32'h11223344, 4'hF);
        push(1'b0, 2'd2, 1'b1, 3'd0, 32'h13, 32'hAB000000, 4'hF);
        push(1'b0, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 4'h0);
        run();
        check_eq("t3_rd", 64'(last_rd), 64'hAB223344);

        push(1'b0, 2'd2, 1'b0, 3'd2, 32'h2, 32'h0, 4'h0);
        push(1'b0, 2'd2, 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, 4'h0);
        push(1'b1, 2'd2, 1'b0, 3'd2, 32'(DEPTH * 4), 32'h0, 4'h0);
        push(1'b0, 2'd2, 1'b1, 3'd2, 32'h12, 32'hFFFFFFFF, 4'hF);
        push(1'b0, 2'd2, 1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 4'hF);
        push(1'b0, 2'd2, 1'b0, 3'd2, 32'h10, 32'h0, 4'h0);
        run();
        check_eq("t4_rd", 64'(last_rd), 64'hAB223344);

        push(1'b1, 2'd2, 1'b1, 3'd2, 32'h20, 32'h5A5A5A5A, 4'hF);
        push(1'b1, 2'd2, 1'b0, 3'd2, 32'h20, 32'h0, 4'h0);
        push(1'b0, 2'd0, 1'b1, 3'd2, 32'h24, 32'hFFFFFFFF, 4'hF);
        push(1'b0, 2'd2, 1'b1, 3'd2, 32'h20, 32'h5A5A5A5A, 4'hF);
        push(1'b0, 2'd1, 1'b1, 3'd2, 32'h20, 32'hFFFFFFFF, 4'hF);
        push(1'b0, 2'd3, 1'b0, 3'd2, 32'h20, 32'h0, 4'h0);
        run();
        check_eq("t5_rd", 64'(last_rd), 64'h5A5A5A5A);

        saved = model_word(1'b1, 32'h30);
        m_sel = 1'b1; m_trans = 2'd2; m_write = 1'b1; m_size = 3'd2; m_addr = 32'h30;
        @(posedge HCLK); #1;
        m_trans = 2'd0; m_wdata = ~saved; m_wstrb = 4'hF;
        check_eq("t6_wait", 64'(s_if1.HREADYOUT), 64'd0);
        #2 HRESETn = 1'b0;
        #1;
        check_eq("t6_rdy", 64'(s_if1.HREADYOUT), 64'd1);
        check_eq("t6_resp", 64'(s_if1.HRESP), 64'd0);
        @(posedge HCLK); #1 HRESETn = 1'b1;
        push(1'b1, 2'd2, 1'b0, 3'd2, 32'h30, 32'h0, 4'h0);
        run();
        check_eq("t6_rd", 64'(last_rd), 64'(saved));

        for (int n = 0; n < 300; n++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            logic [1:0]  tr;
            sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 255));
            else a = 32'($urandom_range(0, DEPTH - 1) * 4) + (32'($urandom_range(0, 3)) & ~((32'd1 << sz) - 1));
            tr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            push(1'($urandom), tr, 1'($urandom), sz, a, $urandom, 4'($urandom));
        end
        run();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
